udma_txbuffer: RTL and testbench

//  Write-path counterpart of the hyperbus RX width converter: takes 32b words from the uDMA TX FIFO and emits PHY beats
//  (16b for HyperRAM/PSRAM, 32b when mem_sel_i==2'b11). Inserts the leading pad for odd start addresses, generates
//  per-byte strobes for partial first/last beats and byte-swaps for PSRAM. Sits between uDMA TX channel and hyper PHY.

---
 rtl/udma_txbuffer_if.sv | 29 ++
 rtl/udma_txbuffer.sv | 212 +++++++++++++++++++++
 tb/tb_udma_txbuffer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/udma_txbuffer_if.sv
// ----------------------------------------------------------------------------
// udma_txbuffer_if
//   Bundles the two streaming handshakes around the TX width converter:
//     src_*  : 32b words coming from the uDMA TX FIFO (valid/ready)
//     dst_*  : PHY beats going to the hyper PHY (valid/ready, data, strobes, last)
//   Modports:
//     slave  : the buffer itself (consumes src words, produces dst beats)
//     master : the environment around it (FIFO side drives src, PHY side drives dst_ready)
// ----------------------------------------------------------------------------
interface udma_txbuffer_if;
    logic        src_valid;
    logic        src_ready;
    logic [31:0] src_data;
    logic        dst_valid;
    logic        dst_ready;
    logic [31:0] dst_data;
    logic [3:0]  dst_strb;
    logic        dst_last;

    modport slave (
        input  src_valid, src_data, dst_ready,
        output src_ready, dst_valid, dst_data, dst_strb, dst_last
    );

    modport master (
        output src_valid, src_data, dst_ready,
        input  src_ready, dst_valid, dst_data, dst_strb, dst_last
    );
endinterface

// File: rtl/udma_txbuffer.sv
// ----------------------------------------------------------------------------
// udma_txbuffer
//   Write-path width converter between the uDMA TX channel and the hyper PHY.
//   Takes 32b words and emits 16b beats (HyperRAM/PSRAM) or 32b beats
//   (mem_sel_i == 2'b11). Prepends pad bytes for odd start addresses, strobes
//   only real payload bytes, and swaps bytes within the 16b lane for PSRAM.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cfg_start_i           pulse: latch cfg_* and start (only honoured when idle)
//   cfg_tx_size_i         payload length in bytes
//   hyper_odd_saaddr_i    odd start address -> W/2 leading pad bytes
//   mem_sel_i             2'b10 PSRAM swap, 2'b11 32b beats, else 16b plain
//   bus (slave)           src word handshake / dst beat handshake
//   busy_o                transfer in progress
//   done_o                one-cycle completion pulse
// ----------------------------------------------------------------------------
module udma_txbuffer #(
    parameter int TRANS_SIZE = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_start_i,
    input  logic [TRANS_SIZE-1:0] cfg_tx_size_i,
    input  logic                  hyper_odd_saaddr_i,
    input  logic [1:0]            mem_sel_i,
    udma_txbuffer_if.slave        bus,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int TS = TRANS_SIZE;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic          done_q, done_d;
    logic          w4_q;
    logic          psram_q;
    logic [2:0]    last_n_q;
    logic [TS-1:0] words_left_q;
    logic [TS-1:0] beats_left_q;
    logic [3:0]    cnt_q;
    logic [63:0]   stg_data_q, stg_data_n;
    logic [7:0]    stg_strb_q, stg_strb_n;

    function automatic logic [15:0] swap_lane(input logic [15:0] d);
        return {d[7:0], d[15:8]};
    endfunction

    function automatic logic [1:0] swap_strb(input logic [1:0] s);
        return {s[0], s[1]};
    endfunction

    // ---------------- start-time configuration ----------------
    logic          start_ok;
    logic          size_zero;
    logic          cfg_w4;
    logic [1:0]    cfg_off;
    logic [TS:0]   cfg_span;
    logic [TS-1:0] cfg_beats;
    logic [TS-1:0] cfg_words;
    logic [2:0]    cfg_last_n;

    assign start_ok  = (state_q == IDLE) && cfg_start_i;
    assign size_zero = (cfg_tx_size_i == '0);
    assign cfg_w4    = (mem_sel_i == 2'b11);
    assign cfg_off   = hyper_odd_saaddr_i ? (cfg_w4 ? 2'd2 : 2'd1) : 2'd0;
    assign cfg_span  = {1'b0, cfg_tx_size_i} + (TS+1)'(cfg_off);

    // Ceiling divisions written as quotient plus "any remainder" so no bit goes unused.
    assign cfg_beats = cfg_w4 ? (TS'(cfg_span[TS:2]) + TS'(|cfg_span[1:0]))
                              : (cfg_span[TS:1] + TS'(cfg_span[0]));
    assign cfg_words = TS'(cfg_tx_size_i[TS-1:2]) + TS'(|cfg_tx_size_i[1:0]);
    // Payload bytes carried by the final source word (1..4).
    assign cfg_last_n = (cfg_tx_size_i[1:0] == 2'b00) ? 3'd4 : {1'b0, cfg_tx_size_i[1:0]};

    // ---------------- handshakes ----------------
    logic       run;
    logic [3:0] w_n;
    logic       words_empty;
    logic       src_ready, dst_valid;
    logic       push_fire, pop_fire;
    logic [3:0] pop_n, pop_amt, push_n, cnt_kept;

    assign run         = (state_q == RUN);
    assign w_n         = w4_q ? 4'd4 : 4'd2;
    assign words_empty = (words_left_q == '0);
    assign src_ready   = run && !words_empty && (cnt_q < w_n);
    // Once every word is in, a short remainder still goes out as a tail-padded beat.
    assign dst_valid   = run && ((cnt_q >= w_n) || (words_empty && (cnt_q != 4'd0)));
    assign push_fire   = src_ready && bus.src_valid;
    assign pop_fire    = dst_valid && bus.dst_ready;
    assign pop_n       = (cnt_q >= w_n) ? w_n : cnt_q;
    assign pop_amt     = pop_fire ? pop_n : 4'd0;
    assign cnt_kept    = cnt_q - pop_amt;
    assign push_n      = (words_left_q == TS'(1)) ? {1'b0, last_n_q} : 4'd4;

    // ---------------- staging shift register ----------------
    logic [31:0] word_data;
    logic [3:0]  word_strb;
    logic [63:0] shifted_data, ins_data;
    logic [7:0]  shifted_strb, ins_strb;

    always_comb begin
        word_data = '0;
        word_strb = '0;
        // Bytes past the end of the payload are dropped: zero data, zero strobe.
        for (int i = 0; i < 4; i++) begin
            word_strb[i] = (4'(i) < push_n);
            word_data[8*i +: 8] = word_strb[i] ? bus.src_data[8*i +: 8] : 8'h00;
        end
        shifted_data = stg_data_q >> {pop_amt, 3'b000};
        shifted_strb = stg_strb_q >> pop_amt;
        ins_data     = {32'h0, word_data} << {cnt_kept, 3'b000};
        ins_strb     = {4'h0, word_strb} << cnt_kept;
        stg_data_n   = '0;
        stg_strb_n   = '0;
        // Bytes above the live count are kept zero so tail padding comes out clean.
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < cnt_kept) begin
                stg_data_n[8*i +: 8] = shifted_data[8*i +: 8];
                stg_strb_n[i]        = shifted_strb[i];
            end else if (push_fire) begin
                stg_data_n[8*i +: 8] = ins_data[8*i +: 8];
                stg_strb_n[i]        = ins_strb[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (start_ok) begin
            // Leading pad bytes are already zero data / zero strobe.
            stg_data_q <= '0;
            stg_strb_q <= '0;
        end else if (run) begin
            stg_data_q <= stg_data_n;
            stg_strb_q <= stg_strb_n;
        end
    end

    // ---------------- control state ----------------
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_start_i) begin
                    if (size_zero) done_d  = 1'b1;
                    else           state_d = RUN;
                end
            end
            RUN: begin
                if (pop_fire && (beats_left_q == TS'(1))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            w4_q         <= 1'b0;
            psram_q      <= 1'b0;
            last_n_q     <= 3'd0;
            words_left_q <= '0;
            beats_left_q <= '0;
            cnt_q        <= 4'd0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (start_ok) begin
                w4_q         <= cfg_w4;
                psram_q      <= (mem_sel_i == 2'b10);
                last_n_q     <= cfg_last_n;
                words_left_q <= cfg_words;
                beats_left_q <= size_zero ? '0 : cfg_beats;
                cnt_q        <= size_zero ? 4'd0 : {2'b00, cfg_off};
            end else if (run) begin
                cnt_q <= cnt_kept + (push_fire ? push_n : 4'd0);
                if (push_fire) words_left_q <= words_left_q - TS'(1);
                if (pop_fire)  beats_left_q <= beats_left_q - TS'(1);
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        bus.dst_data = '0;
        bus.dst_strb = '0;
        if (dst_valid) begin
            if (w4_q) begin
                bus.dst_data = stg_data_q[31:0];
                bus.dst_strb = stg_strb_q[3:0];
            end else if (psram_q) begin
                bus.dst_data = {16'h0, swap_lane(stg_data_q[15:0])};
                bus.dst_strb = {2'b00, swap_strb(stg_strb_q[1:0])};
            end else begin
                bus.dst_data = {16'h0, stg_data_q[15:0]};
                bus.dst_strb = {2'b00, stg_strb_q[1:0]};
            end
        end
    end

    assign bus.src_ready = src_ready;
    assign bus.dst_valid = dst_valid;
    assign bus.dst_last  = dst_valid && (beats_left_q == TS'(1));
    assign busy_o        = run;
    assign done_o        = done_q;
endmodule

// File: tb/tb_udma_txbuffer.sv
// ----------------------------------------------------------------------------
// tb_udma_txbuffer
//   Self-checking bench for udma_txbuffer: a table of fixed transfers with
//   hand-derived beats, hand-written stall / reset / zero-size sequences, and
//   randomized transfers compared against a byte-stream reference model.
// ----------------------------------------------------------------------------
module tb_udma_txbuffer;
    localparam int TS = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cfg_start_i;
    logic [TS-1:0] cfg_tx_size_i;
    logic          hyper_odd_saaddr_i;
    logic [1:0]    mem_sel_i;
    logic          busy_o;
    logic          done_o;

    udma_txbuffer_if bus();

    udma_txbuffer #(.TRANS_SIZE(TS)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .cfg_start_i        (cfg_start_i),
        .cfg_tx_size_i      (cfg_tx_size_i),
        .hyper_odd_saaddr_i (hyper_odd_saaddr_i),
        .mem_sel_i          (mem_sel_i),
        .bus                (bus),
        .busy_o             (busy_o),
        .done_o             (done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] src_words[$];
    logic [31:0] exp_d[$];
    logic [3:0]  exp_s[$];
    logic [31:0] rx_d[$];
    logic [3:0]  rx_s[$];

    typedef struct {
        int              size;
        bit              odd;
        logic [1:0]      sel;
        logic [31:0]     w0;
        logic [31:0]     w1;
        int              nb;
        logic [2:0][31:0] d;
        logic [2:0][3:0]  s;
    } vec_t;

    vec_t vec[4];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endfunction

    // Reference model: lay out the byte stream (lead pad, payload, tail pad),
    // cut it into W-byte beats, then apply the PSRAM lane swap.
    function automatic void build_exp(input int size, input bit odd, input logic [1:0] sel);
        int w, off, nb;
        w   = (sel == 2'b11) ? 4 : 2;
        off = odd ? w / 2 : 0;
        nb  = (size == 0) ? 0 : (off + size + w - 1) / w;
        exp_d.delete();
        exp_s.delete();
        for (int b = 0; b < nb; b++) begin
            logic [31:0] d;
            logic [3:0]  s;
            d = '0;
            s = '0;
            for (int j = 0; j < w; j++) begin
                int k;
                k = b * w + j - off;
                if (k >= 0 && k < size) begin
                    logic [31:0] wd;
                    wd = src_words[k / 4];
                    d[8*j +: 8] = wd[8*(k % 4) +: 8];
                    s[j] = 1'b1;
                end
            end
            if (sel == 2'b10) begin
                d = {16'h0, d[7:0], d[15:8]};
                s = {2'b00, s[0], s[1]};
            end
            exp_d.push_back(d);
            exp_s.push_back(s);
        end
    endfunction

    task automatic do_xfer(input int size, input bit odd, input logic [1:0] sel,
                           input int src_p, input int dst_p, input int stall_beat,
                           input int abort_at, input bit poke_cfg);
        int nwords, widx, got, cyc;
        bit done_seen, stalled;
        logic [31:0] sd;
        logic [3:0]  ss;
        logic        sl, el;
        nwords = (size + 3) / 4;
        widx = 0; got = 0; cyc = 0; done_seen = 0; stalled = 0;
        build_exp(size, odd, sel);
        rx_d.delete();
        rx_s.delete();
        cfg_tx_size_i      = size[TS-1:0];
        hyper_odd_saaddr_i = odd;
        mem_sel_i          = sel;
        cfg_start_i        = 1'b1;
        @(negedge clk_i);
        cfg_start_i = 1'b0;
        if (size != 0) chk("busy_after_start", busy_o, 1);
        while (cyc < 4000) begin
            if (done_o) begin
                done_seen = 1;
                break;
            end
            if (cyc == abort_at) begin
                rst_i = 1'b1;
                bus.src_valid = 1'b0;
                bus.dst_ready = 1'b0;
                cfg_start_i = 1'b0;
                #1;
                chk("abort_outputs", {bus.src_ready, bus.dst_valid, bus.dst_last, busy_o, done_o,
                                      bus.dst_data, bus.dst_strb}, 0);
                @(negedge clk_i);
                rst_i = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk_i);
                    chk("abort_no_done", {done_o, busy_o, bus.dst_valid}, 0);
                end
                return;
            end
            if (stall_beat >= 0 && !stalled && got == stall_beat && bus.dst_valid) begin
                stalled = 1;
                sd = bus.dst_data; ss = bus.dst_strb; sl = bus.dst_last;
                bus.dst_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    bus.src_valid = (widx < nwords);
                    bus.src_data  = (widx < nwords) ? src_words[widx] : 32'h0;
                    if (bus.src_valid && bus.src_ready) widx++;
                    @(negedge clk_i);
                    cyc++;
                    chk("stall_valid", bus.dst_valid, 1);
                    chk("stall_beat_stable", {bus.dst_data, bus.dst_strb, bus.dst_last}, {sd, ss, sl});
                    chk("stall_src_ready", bus.src_ready, 0);
                end
            end
            bus.src_valid = (widx < nwords) && ($urandom_range(0, 99) < src_p);
            bus.src_data  = (widx < nwords) ? src_words[widx] : $urandom;
            bus.dst_ready = ($urandom_range(0, 99) < dst_p);
            if (poke_cfg) begin
                cfg_start_i        = ($urandom_range(0, 9) == 0);
                cfg_tx_size_i      = TS'($urandom);
                hyper_odd_saaddr_i = 1'($urandom);
                mem_sel_i          = 2'($urandom);
            end
            if (bus.dst_valid && bus.dst_ready) begin
                if (got < exp_d.size()) begin
                    el = (got == exp_d.size() - 1);
                    chk("beat", {bus.dst_data, bus.dst_strb, bus.dst_last}, {exp_d[got], exp_s[got], el});
                end else begin
                    chk("extra_beat", bus.dst_valid, 0);
                end
                rx_d.push_back(bus.dst_data);
                rx_s.push_back(bus.dst_strb);
                got++;
            end
            if (bus.src_valid && bus.src_ready) widx++;
            @(negedge clk_i);
            cyc++;
        end
        bus.src_valid = 1'b0;
        bus.dst_ready = 1'b0;
        cfg_start_i   = 1'b0;
        chk("done_seen", done_seen, 1);
        chk("beat_count", got, exp_d.size());
        chk("words_consumed", widx, nwords);
        chk("idle_at_done", {busy_o, bus.dst_valid}, 0);
        @(negedge clk_i);
        chk("done_one_cycle", done_o, 0);
    endtask

    initial begin
        vec[0] = '{4, 1'b0, 2'b00, 32'hDDCCBBAA, 32'h0, 2,
                   {32'h0, 32'h0000DDCC, 32'h0000BBAA}, {4'h0, 4'b0011, 4'b0011}};
        vec[1] = '{3, 1'b1, 2'b00, 32'h00CCBBAA, 32'h0, 2,
                   {32'h0, 32'h0000CCBB, 32'h0000AA00}, {4'h0, 4'b0011, 4'b0010}};
        vec[2] = '{5, 1'b0, 2'b10, 32'h44332211, 32'h00000055, 3,
                   {32'h00005500, 32'h00003344, 32'h00001122}, {4'b0010, 4'b0011, 4'b0011}};
        vec[3] = '{6, 1'b1, 2'b11, 32'h44332211, 32'h00006655, 2,
                   {32'h0, 32'h66554433, 32'h22110000}, {4'h0, 4'b1111, 4'b1100}};

        rst_i = 1'b1;
        cfg_start_i = 1'b0;
        cfg_tx_size_i = '0;
        hyper_odd_saaddr_i = 1'b0;
        mem_sel_i = 2'b00;
        bus.src_valid = 1'b0;
        bus.src_data  = 32'h0;
        bus.dst_ready = 1'b0;

        #12;
        chk("reset_outputs", {bus.src_ready, bus.dst_valid, bus.dst_last, busy_o, done_o,
                              bus.dst_data, bus.dst_strb}, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Source traffic while idle must not be accepted.
        bus.src_valid = 1'b1;
        bus.src_data  = 32'h12345678;
        @(negedge clk_i);
        chk("idle_src_ready", bus.src_ready, 0);
        chk("idle_busy", busy_o, 0);
        bus.src_valid = 1'b0;

        for (int t = 0; t < 4; t++) begin
            src_words.delete();
            src_words.push_back(vec[t].w0);
            src_words.push_back(vec[t].w1);
            do_xfer(vec[t].size, vec[t].odd, vec[t].sel, 100, 100, -1, -1, 1'b0);
            chk("tbl_nbeats", rx_d.size(), vec[t].nb);
            for (int b = 0; b < vec[t].nb && b < rx_d.size(); b++)
                chk("tbl_beat", {rx_d[b], rx_s[b]}, {vec[t].d[b], vec[t].s[b]});
        end

        // Downstream stall mid-transfer, 16b and 32b modes.
        src_words.delete();
        for (int i = 0; i < 3; i++) src_words.push_back($urandom);
        do_xfer(12, 1'b0, 2'b00, 100, 100, 1, -1, 1'b0);
        do_xfer(10, 1'b1, 2'b11, 100, 100, 1, -1, 1'b0);

        // Zero-length transfer.
        src_words.delete();
        do_xfer(0, 1'b1, 2'b11, 100, 100, -1, -1, 1'b0);

        // Reset in the middle of a transfer, then a clean one.
        src_words.delete();
        for (int i = 0; i < 4; i++) src_words.push_back($urandom);
        do_xfer(16, 1'b0, 2'b00, 100, 100, -1, 4, 1'b0);
        do_xfer(7, 1'b1, 2'b10, 100, 100, -1, -1, 1'b0);

        // Randomized transfers with random back-pressure and ignored restarts.
        for (int r = 0; r < 24; r++) begin
            int size;
            size = $urandom_range(0, 40);
            src_words.delete();
            for (int i = 0; i < (size + 3) / 4; i++) src_words.push_back($urandom);
            do_xfer(size, 1'($urandom), 2'($urandom), $urandom_range(40, 100),
                    $urandom_range(40, 100), -1, -1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
